// File: rtl/user_eth_udp_cfg_seq.sv
// rtl/user_eth_udp_cfg_seq.sv - AXI4-Lite master that writes four config registers, optional readback.
// Optional readback-compare phase enabled by defining USER_ETH_UDP_CFG_READBACK_EN.
module user_eth_udp_cfg_seq #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic [127:0]                    cfg_word,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [1:0]                      err_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_FIN
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  state_t                                state_q;
  logic [1:0]                            idx_q;
  logic [1:0]                            idx_d;
  logic [127:0]                          snap_q;
  logic                                  aw_done_q;
  logic                                  w_done_q;
  logic                                  busy_q;
  logic                                  done_q;
  logic                                  error_q;
  logic [1:0]                            err_index_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]         awaddr_q;
  logic                                  awvalid_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]         wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]       wstrb_q;
  logic                                  wvalid_q;
  logic                                  bready_q;
  logic                                  aw_hs;
  logic                                  w_hs;
`ifdef USER_ETH_UDP_CFG_READBACK_EN
  logic [C_M_AXI_ADDR_WIDTH-1:0]         araddr_q;
  logic                                  arvalid_q;
  logic                                  rready_q;
`endif

  function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] i);
    return C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({i, 2'b00});
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
    return v[32*i +: 32];
  endfunction

  assign idx_d = idx_q + 2'd1;
  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q & M_AXI_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      snap_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= 2'd0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
`ifdef USER_ETH_UDP_CFG_READBACK_EN
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            snap_q      <= cfg_word;
            error_q     <= 1'b0;
            err_index_q <= 2'd0;
            idx_q       <= 2'd0;
            busy_q      <= 1'b1;
            awaddr_q    <= reg_addr(2'd0);
            wdata_q     <= cfg_word[31:0];
            wstrb_q     <= '1;
            awvalid_q   <= 1'b1;
            wvalid_q    <= 1'b1;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            state_q     <= S_WR;
          end
        end
        // AW and W complete independently; wait for both before taking B.
        S_WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID && bready_q) begin
            bready_q <= 1'b0;
            if (M_AXI_BRESP != RESP_OKAY) begin
              error_q     <= 1'b1;
              err_index_q <= idx_q;
              done_q      <= 1'b1;
              state_q     <= S_FIN;
            end else if (idx_q != 2'd3) begin
              idx_q     <= idx_d;
              awaddr_q  <= reg_addr(idx_d);
              wdata_q   <= word_of(snap_q, idx_d);
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= S_WR;
            end else begin
`ifdef USER_ETH_UDP_CFG_READBACK_EN
              idx_q     <= 2'd0;
              araddr_q  <= reg_addr(2'd0);
              arvalid_q <= 1'b1;
              state_q   <= S_RD;
`else
              done_q    <= 1'b1;
              state_q   <= S_FIN;
`endif
            end
          end
        end
`ifdef USER_ETH_UDP_CFG_READBACK_EN
        S_RD: begin
          if (arvalid_q && M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (M_AXI_RVALID && rready_q) begin
            rready_q <= 1'b0;
            if (M_AXI_RRESP != RESP_OKAY || M_AXI_RDATA != word_of(snap_q, idx_q)) begin
              error_q     <= 1'b1;
              err_index_q <= idx_q;
              done_q      <= 1'b1;
              state_q     <= S_FIN;
            end else if (idx_q != 2'd3) begin
              idx_q     <= idx_d;
              araddr_q  <= reg_addr(idx_d);
              arvalid_q <= 1'b1;
              state_q   <= S_RD;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end
          end
        end
`endif
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_index     = err_index_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARPROT  = 3'b000;

`ifdef USER_ETH_UDP_CFG_READBACK_EN
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
`else
  logic unused_rd;
  assign unused_rd     = &{1'b0, M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_user_eth_udp_cfg_seq.sv
// tb/tb_user_eth_udp_cfg_seq.sv - directed bench for user_eth_udp_cfg_seq with a reactive AXI4-Lite slave.
module tb_user_eth_udp_cfg_seq;
  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         start = 1'b0;
  logic [127:0] cfg_word = '0;
  logic         busy, done, error;
  logic [1:0]   err_index;
  logic [31:0]  M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]   M_AXI_WSTRB;
  logic         M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic         M_AXI_AWREADY = 1'b0;
  logic         M_AXI_WREADY = 1'b0;
  logic [1:0]   M_AXI_BRESP = 2'b00;
  logic         M_AXI_BVALID = 1'b0;
  logic         M_AXI_ARREADY = 1'b0;
  logic [31:0]  M_AXI_RDATA = '0;
  logic [1:0]   M_AXI_RRESP = 2'b00;
  logic         M_AXI_RVALID = 1'b0;

  user_eth_udp_cfg_seq dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_word(cfg_word),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int miscompares = 0;

  // Slave knobs, owned by the stimulus block.
  int          aw_lat [4] = '{0, 0, 0, 0};
  int          w_lat  [4] = '{0, 0, 0, 0};
  logic [31:0] exp_mem[4] = '{0, 0, 0, 0};
  logic        b_err_en = 1'b0;
  logic [31:0] b_err_addr = '0;
  logic        r_err_en = 1'b0;
  logic [31:0] r_err_addr = '0;

  // Monitor state, owned by the posedge block.
  int          cyc = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, done_cnt = 0;
  int          aw_alone = 0, w_alone = 0, viol = 0;
  int          b_cyc_last = 0, r_cyc_last = 0, done_cyc_last = 0;
  logic [31:0] aw_log[64], w_log[64], ar_log[64];
  int          aw_cyc[64], w_cyc[64];
  logic [31:0] last_awaddr = '0, last_araddr = '0;
  logic        b_hs_q = 1'b0, r_hs_q = 1'b0;
  logic        pv_aw = 1'b0, pv_w = 1'b0, pv_ar = 1'b0;
  logic        p_awhs = 1'b0, p_whs = 1'b0, p_arhs = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

  always @(posedge ACLK) begin
    cyc++;
    if (ARESETN) begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_log[aw_cnt % 64] = M_AXI_AWADDR;
        aw_cyc[aw_cnt % 64] = cyc;
        last_awaddr = M_AXI_AWADDR;
        aw_cnt++;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_log[w_cnt % 64] = M_AXI_WDATA;
        w_cyc[w_cnt % 64] = cyc;
        if (M_AXI_WSTRB !== 4'hF) viol++;
        w_cnt++;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        b_cnt++;
        b_cyc_last = cyc;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_log[ar_cnt % 64] = M_AXI_ARADDR;
        last_araddr = M_AXI_ARADDR;
        ar_cnt++;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        r_cnt++;
        r_cyc_last = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc_last = cyc;
      end
      if (M_AXI_AWVALID && !M_AXI_WVALID) aw_alone++;
      if (M_AXI_WVALID && !M_AXI_AWVALID) w_alone++;
      if (pv_aw && !p_awhs && (!M_AXI_AWVALID || M_AXI_AWADDR !== p_awaddr)) viol++;
      if (pv_w && !p_whs && (!M_AXI_WVALID || M_AXI_WDATA !== p_wdata)) viol++;
      if (pv_ar && !p_arhs && (!M_AXI_ARVALID || M_AXI_ARADDR !== p_araddr)) viol++;
      if ((M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY) && (M_AXI_ARVALID || M_AXI_RREADY)) viol++;
      if (M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) viol++;
      b_hs_q   = M_AXI_BVALID && M_AXI_BREADY;
      r_hs_q   = M_AXI_RVALID && M_AXI_RREADY;
      pv_aw    = M_AXI_AWVALID;
      p_awhs   = M_AXI_AWVALID && M_AXI_AWREADY;
      p_awaddr = M_AXI_AWADDR;
      pv_w     = M_AXI_WVALID;
      p_whs    = M_AXI_WVALID && M_AXI_WREADY;
      p_wdata  = M_AXI_WDATA;
      pv_ar    = M_AXI_ARVALID;
      p_arhs   = M_AXI_ARVALID && M_AXI_ARREADY;
      p_araddr = M_AXI_ARADDR;
    end else begin
      b_hs_q = 1'b0;
      r_hs_q = 1'b0;
      pv_aw  = 1'b0;
      pv_w   = 1'b0;
      pv_ar  = 1'b0;
    end
  end

  // Slave responder: decides READY/VALID on the falling edge for the next rising edge.
  int aw_wait = 0, w_wait = 0, b_issued = 0, r_issued = 0;
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      M_AXI_AWREADY = 1'b0;
      M_AXI_WREADY  = 1'b0;
      M_AXI_BVALID  = 1'b0;
      M_AXI_ARREADY = 1'b0;
      M_AXI_RVALID  = 1'b0;
      aw_wait  = 0;
      w_wait   = 0;
      b_issued = (aw_cnt > w_cnt) ? aw_cnt : w_cnt;
      r_issued = ar_cnt;
    end else begin
      if (b_hs_q) M_AXI_BVALID = 1'b0;
      if (r_hs_q) M_AXI_RVALID = 1'b0;
      if (!M_AXI_BVALID && aw_cnt > b_issued && w_cnt > b_issued) begin
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = (b_err_en && last_awaddr == b_err_addr) ? 2'b10 : 2'b00;
        b_issued++;
      end
      if (!M_AXI_RVALID && ar_cnt > r_issued) begin
        M_AXI_RVALID = 1'b1;
        M_AXI_RRESP  = 2'b00;
        M_AXI_RDATA  = (r_err_en && last_araddr == r_err_addr) ? 32'hDEAD : exp_mem[last_araddr[3:2]];
        r_issued++;
      end
      M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_lat[M_AXI_AWADDR[3:2]]);
      aw_wait       = M_AXI_AWVALID ? aw_wait + 1 : 0;
      M_AXI_WREADY  = M_AXI_WVALID && (w_wait >= w_lat[M_AXI_AWADDR[3:2]]);
      w_wait        = M_AXI_WVALID ? w_wait + 1 : 0;
      M_AXI_ARREADY = M_AXI_ARVALID;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [127:0] cw);
    @(negedge ACLK);
    cfg_word = cw;
    start    = 1'b1;
    @(negedge ACLK);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int a0, w0, b0, ar0, r0, d0, awl0, wl0;

  task automatic take_base();
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt; d0 = done_cnt;
    awl0 = aw_alone; wl0 = w_alone;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge ACLK);
    chk("rst_status", {busy, done, error, err_index}, 5'b0);
    chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
    chk("rst_awaddr", M_AXI_AWADDR, 32'h0);
    chk("rst_wdata", M_AXI_WDATA, 32'h0);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // Clean sequence, always-ready OKAY slave
    exp_mem = '{32'd1, 32'd2, 32'd3, 32'd4};
    take_base();
    pulse_start({32'd4, 32'd3, 32'd2, 32'd1});
    chk("t1_busy", busy, 1'b1);
    chk("t1_valids", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    chk("t1_awaddr0", M_AXI_AWADDR, 32'h0);
    chk("t1_wdata0", M_AXI_WDATA, 32'd1);
    chk("t1_wstrb", M_AXI_WSTRB, 4'hF);
    wait_done("t1");
    repeat (3) @(negedge ACLK);
    chk("t1_aw_count", aw_cnt - a0, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_awaddr%0d", i), aw_log[(a0 + i) % 64], 32'(4 * i));
      chk($sformatf("t1_wdata%0d", i), w_log[(w0 + i) % 64], 32'(i + 1));
    end
    chk("t1_b_count", b_cnt - b0, 4);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_error", error, 1'b0);
    chk("t1_busy_end", busy, 1'b0);
`ifdef USER_ETH_UDP_CFG_READBACK_EN
    chk("t1_ar_count", ar_cnt - ar0, 4);
    chk("t1_r_count", r_cnt - r0, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_araddr%0d", i), ar_log[(ar0 + i) % 64], 32'(4 * i));
    chk("t1_done_after_last_r", done_cyc_last - r_cyc_last, 1);
`else
    chk("t1_ar_count", ar_cnt - ar0, 0);
    chk("t1_done_after_last_b", done_cyc_last - b_cyc_last, 1);
`endif
    chk("t1_protocol", viol, 0);

    // SLVERR on write to 0x4
    b_err_en = 1'b1;
    b_err_addr = 32'h4;
    exp_mem = '{32'h11, 32'h22, 32'h33, 32'h44};
    take_base();
    pulse_start({32'h44, 32'h33, 32'h22, 32'h11});
    wait_done("t2");
    chk("t2_error", error, 1'b1);
    chk("t2_err_index", err_index, 2'd1);
    repeat (5) @(negedge ACLK);
    chk("t2_error_hold", {error, err_index}, 3'b101);
    chk("t2_aw_count", aw_cnt - a0, 2);
    chk("t2_last_aw", aw_log[(aw_cnt - 1) % 64], 32'h4);
    chk("t2_ar_count", ar_cnt - ar0, 0);
    chk("t2_done_count", done_cnt - d0, 1);
    b_err_en = 1'b0;

`ifdef USER_ETH_UDP_CFG_READBACK_EN
    // Readback miscompare on 0x8
    r_err_en = 1'b1;
    r_err_addr = 32'h8;
    exp_mem = '{32'd1, 32'd2, 32'd3, 32'd4};
    take_base();
    pulse_start({32'd4, 32'd3, 32'd2, 32'd1});
    chk("t3_error_cleared", error, 1'b0);
    wait_done("t3");
    repeat (3) @(negedge ACLK);
    chk("t3_error", {error, err_index}, 3'b110);
    chk("t3_ar_count", ar_cnt - ar0, 3);
    chk("t3_last_ar", ar_log[(ar_cnt - 1) % 64], 32'h8);
    chk("t3_done_count", done_cnt - d0, 1);
    r_err_en = 1'b0;
    b_err_en = 1'b1;
    b_err_addr = 32'h0;
    pulse_start({32'd4, 32'd3, 32'd2, 32'd1});
    wait_done("t3b");
    b_err_en = 1'b0;
`endif

    // Independent AW/W handshake timing
    aw_lat = '{3, 0, 1, 2};
    w_lat  = '{0, 2, 1, 0};
    exp_mem = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    take_base();
    pulse_start({32'hA4, 32'hA3, 32'hA2, 32'hA1});
    chk("t4_error_cleared", error, 1'b0);
    wait_done("t4");
    repeat (3) @(negedge ACLK);
    chk("t4_reg0_w_first", aw_cyc[a0 % 64] - w_cyc[w0 % 64], 3);
    chk("t4_reg1_aw_first", w_cyc[(w0 + 1) % 64] - aw_cyc[(a0 + 1) % 64], 2);
    chk("t4_reg2_same", aw_cyc[(a0 + 2) % 64] - w_cyc[(w0 + 2) % 64], 0);
    chk("t4_aw_alone", aw_alone - awl0, 5);
    chk("t4_w_alone", w_alone - wl0, 2);
    chk("t4_b_count", b_cnt - b0, 4);
    chk("t4_aw_count", aw_cnt - a0, 4);
    chk("t4_wdata3", w_log[(w0 + 3) % 64], 32'hA4);
    chk("t4_error", error, 1'b0);
    chk("t4_protocol", viol, 0);
    aw_lat = '{0, 0, 0, 0};
    w_lat  = '{0, 0, 0, 0};

    // Start re-pulsed while busy
    exp_mem = '{32'h10, 32'h20, 32'h30, 32'h40};
    take_base();
    pulse_start({32'h40, 32'h30, 32'h20, 32'h10});
    @(negedge ACLK);
    pulse_start({32'hFF, 32'hEE, 32'hDD, 32'hCC});
    wait_done("t5");
    repeat (10) @(negedge ACLK);
    chk("t5_aw_count", aw_cnt - a0, 4);
    chk("t5_done_count", done_cnt - d0, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t5_wdata%0d", i), w_log[(w0 + i) % 64], 32'(16 * (i + 1)));
    chk("t5_busy_end", busy, 1'b0);

    // Reset asserted during WR_RESP
    exp_mem = '{32'd1, 32'd2, 32'd3, 32'd4};
    pulse_start({32'd4, 32'd3, 32'd2, 32'd1});
    begin
      int n = 0;
      while (M_AXI_BREADY !== 1'b1 && n < 50) begin
        @(negedge ACLK);
        n++;
      end
    end
    chk("t6_in_wr_resp", M_AXI_BREADY, 1'b1);
    ARESETN = 1'b0;
    #1;
    chk("t6_rst_status", {busy, done, error, err_index}, 5'b0);
    chk("t6_rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
    chk("t6_rst_addr", {M_AXI_AWADDR | M_AXI_ARADDR}, 32'h0);
    chk("t6_rst_wdata", M_AXI_WDATA, 32'h0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    take_base();
    repeat (5) @(negedge ACLK);
    chk("t6_no_resume", {busy, M_AXI_AWVALID, M_AXI_WVALID}, 3'b000);
    chk("t6_no_resume_aw", aw_cnt - a0, 0);
    pulse_start({32'd4, 32'd3, 32'd2, 32'd1});
    wait_done("t6");
    repeat (3) @(negedge ACLK);
    chk("t6_aw_count", aw_cnt - a0, 4);
    chk("t6_b_count", b_cnt - b0, 4);
    chk("t6_last_aw", aw_log[(a0 + 3) % 64], 32'hC);
    chk("t6_done_count", done_cnt - d0, 1);
    chk("t6_error", error, 1'b0);
    chk("t6_protocol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/user_eth_udp_cfg_seq.md
USER_ETH_UDP_CFG_SEQ -- requirements
Module: user_eth_udp_cfg_seq

Interface
REQ-001 The block SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 The block SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 is supported).
REQ-003 The block SHALL have parameter C_BASE_ADDR, default 0, byte address of configuration register 0.
REQ-004 The block SHALL have port ACLK, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port ARESETN, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, single-cycle request to run one programming sequence.
REQ-007 The block SHALL have port cfg_word, input, 4x32 (128 bits), the four register values; word i occupies bits [32i+31:32i].
REQ-008 The block SHALL have ports busy (1), done (1), error (1) and err_index (2), all outputs, giving status.
REQ-009 The block SHALL provide an AXI4-Lite master: M_AXI_AWADDR/AWPROT/AWVALID, AWREADY, WDATA/WSTRB/WVALID, WREADY, BRESP/BVALID, BREADY, ARADDR/ARPROT/ARVALID, ARREADY, RDATA/RRESP/RVALID, RREADY; directions are per AXI4-Lite master.

Function
REQ-010 The FSM SHALL have states IDLE, WR, WR_RESP, RD, RD_DATA and FIN, plus a 2-bit register index idx.
REQ-011 In IDLE, start=1 SHALL capture cfg_word into an internal snapshot, clear error, set idx=0 and enter WR on the next cycle; busy SHALL be 1 in every state except IDLE.
REQ-012 start while busy=1 SHALL be ignored, with no queueing.
REQ-013 On entering WR, AWVALID and WVALID SHALL rise together, with AWADDR=C_BASE_ADDR+4*idx, WDATA=snapshot[idx], WSTRB=4'hF and AWPROT=ARPROT=3'b000.
REQ-014 AWVALID and WVALID SHALL each drop the cycle after their own handshake; the handshakes can complete in either order or in the same cycle; WR_RESP SHALL be entered only once both have completed.
REQ-015 BREADY SHALL be 1 in WR_RESP; on a B handshake, BRESP=OKAY with idx<3 SHALL increment idx and return to WR; BRESP=OKAY with idx=3 SHALL proceed per REQ-024/025.
REQ-016 A B or R handshake with a response other than OKAY SHALL set error=1 and err_index=idx and go to FIN, leaving later registers untouched.
REQ-017 In RD, ARVALID SHALL be 1 with ARADDR=C_BASE_ADDR+4*idx and SHALL drop after the AR handshake, entering RD_DATA.
REQ-018 RREADY SHALL be 1 in RD_DATA; on an R handshake, RDATA not equal to snapshot[idx] SHALL set error=1 and err_index=idx and go to FIN; on a match, idx<3 SHALL increment idx and return to RD, and idx=3 SHALL go to FIN.
REQ-019 FIN SHALL pulse done=1 for exactly one cycle and then return to IDLE; error and err_index SHALL hold until the next accepted start.
REQ-020 No VALID output SHALL be deasserted before its handshake, and the address/data outputs SHALL stay stable while their VALID is 1.
REQ-021 At most one outstanding transaction SHALL exist; reads SHALL never overlap writes.

Reset
REQ-022 ARESETN=0 SHALL asynchronously force IDLE with idx=0 and busy=done=error=0, err_index=0, all VALID and READY outputs 0, and address/data outputs 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the sequence with no resumption; after release, the block SHALL wait for a new start.

Configuration
REQ-024 With macro USER_ETH_UDP_CFG_READBACK_EN defined, a successful final write SHALL set idx=0 and enter RD, and the readback-compare phase (REQ-017/018) SHALL be included.
REQ-025 Without USER_ETH_UDP_CFG_READBACK_EN, the RD/RD_DATA logic SHALL be removed, a successful final write SHALL go directly to FIN, and ARVALID and RREADY SHALL be tied to 0.

Verification
REQ-026 The bench SHALL cover: C_BASE_ADDR=0, cfg_word={4,3,2,1}, start, always-ready OKAY slave -> writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then readback of the same values, done pulses once, error=0.
REQ-027 The bench SHALL cover: slave returns 0xDEAD on the read of 0x8 -> error=1, err_index=2, no read of 0xC, done pulses.
REQ-028 The bench SHALL cover: BRESP=SLVERR on the write to 0x4 -> error=1, err_index=1, no AW to 0x8, no reads issued.
REQ-029 The bench SHALL cover: WREADY 3 cycles before AWREADY, then AWREADY before WREADY -> each VALID drops independently, and exactly one B per register.
REQ-030 The bench SHALL cover: start re-pulsed while busy -> one sequence only; ARESETN low during WR_RESP -> all outputs 0 immediately, and a subsequent start runs a full sequence.
REQ-031 The bench SHALL cover: build without USER_ETH_UDP_CFG_READBACK_EN -> 4 writes, ARVALID stays 0, done one cycle after the 4th B handshake.
